if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter, drives the combinational instruction memory's word address, and captures the returned instruction into the IF/ID pipeline register. Applies redirects: jump/jal/jr resolved in ID, branches resolved in EX. Also applies hazard-unit stalls, and inserts bubbles on every redirect. Sits directly upstream of the instruction memory (address side) and the decode stage (IF/ID side).

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset. The CPU starts at 0x0, not the MARS 0x0040_0000.
- NOP_WORD, 32'h0000_0000, instruction word written into IF/ID as a bubble.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  32  current PC; feeds the instruction memory Address. The memory decodes bits [9:2].
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- stall  input  1  hazard-unit hold, used for load-use hazards.
- id_redirect  input  1  ID has resolved j/jal/jr this cycle.
- id_target  input  32  jump target from ID.
- ex_redirect  input  1  EX has resolved a taken beq/bne this cycle.
- ex_target  input  32  branch target from EX.
- ifid_instr  output  32  registered instruction for ID.
- ifid_pc_plus4  output  32  registered PC+4 of that instruction; ID uses it as the jal link value and the jump-target base.
- ifid_valid  output  1  1 = ifid_instr is a real fetched instruction; 0 = bubble.
- fetch_count  output  32  number of instructions accepted into IF/ID since reset.

## Operation
- imem_addr = pc, purely combinational; no extra delay.
- On every rising edge the block applies the first matching row, in this priority order:
  1. reset:
     - pc <= RESET_PC
     - ifid_instr <= NOP_WORD; ifid_pc_plus4 <= 0; ifid_valid <= 0
     - fetch_count <= 0
  2. ex_redirect:
     - pc <= ex_target
     - IF/ID <= bubble (NOP_WORD, pc_plus4 0, valid 0)
     - The older instruction in ID is flushed by the downstream ID/EX logic, not here.
  3. id_redirect:
     - pc <= id_target
     - IF/ID <= bubble
  4. stall:
     - pc, IF/ID and fetch_count all hold.
  5. normal fetch:
     - pc <= pc + 4
     - ifid_instr <= imem_instr; ifid_pc_plus4 <= pc + 4; ifid_valid <= 1
     - fetch_count <= fetch_count + 1
- Redirects override stall: a stall asserted together with either redirect is ignored for that cycle.
- ex_redirect together with id_redirect: EX wins, because the ID jump lies on the squashed path.
- Arithmetic rules:
  - All PC arithmetic is 32-bit unsigned and wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
  - fetch_count wraps at 2^32.
- Target alignment: targets are used as given; no alignment check. imem_addr[1:0] are passed through, and the memory ignores them.
- FSM: none beyond the priority rows above. The stage has one implicit state (running), re-entered after reset.

## Timing
- Fetch latency: 1 cycle. The instruction at address A appears on ifid_instr in the cycle after pc == A with no stall or redirect.
- Redirect penalty:
  - id_redirect: 1 bubble.
  - ex_redirect: 1 bubble in IF/ID, plus the ID-side flush done downstream.
  - In both cases the target instruction reaches IF/ID two edges after the redirect edge.
- Stall: holds for exactly as many cycles as stall is high, with no lost or duplicated fetch.
- Reset mid-operation: the next edge with reset high discards all in-flight state. The first fetch from RESET_PC is captured on the first edge with reset low.

## Structure
- Shared pipeline package holds:
  - RESET_PC and NOP_WORD defaults.
  - Opcode constants for j (6'h02), jal (6'h03), beq (6'h04), bne (6'h05), used by ID/EX.
  - A 65-bit IF/ID record typedef {instr, pc_plus4, valid} shared with the decode stage.
- One sub-module is natural: ifid_reg, the IF/ID register with flush (bubble) and enable (hold) controls, reused as a template for the later pipeline registers. The PC register and next-PC mux stay in if_stage.

## Test plan
- **Reset and first fetch:** reset high for 2 cycles, then low, with imem returning 32'h20040000 at 0.
  - During and after the reset edges: imem_addr = 0, ifid_valid = 0, fetch_count = 0.
  - After the first post-reset edge: ifid_instr = 32'h20040000, ifid_pc_plus4 = 4, imem_addr = 4.
- **Sequential fetch:** 5 free cycles.
  - imem_addr steps 0, 4, 8, 12, 16, 20.
  - fetch_count = 5.
  - Each ifid_pc_plus4 = its instruction address + 4.
- **Stall:** stall high for 2 cycles at pc = 8.
  - pc, ifid_instr and fetch_count all hold.
  - On release, the instruction at 8 is captured exactly once.
- **Jump:** id_redirect with id_target = 0x30 while pc = 0x30 is not yet reached.
  - Next cycle: pc = 0x30 and ifid_valid = 0.
  - Following cycle: the instruction at 0x30 is in IF/ID.
- **Priority:** ex_redirect (target 0x40), id_redirect (target 0x60) and stall all high together.
  - pc = 0x40, bubble in IF/ID, fetch_count unchanged.
- **Wrap and mid-run reset:**
  - Force pc = 0xFFFF_FFFC and run one free cycle → pc = 0.
  - Assert reset mid-run → all outputs return to their reset values on that edge.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline package: reset defaults, control-flow opcodes and the IF/ID record.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  // Control-flow opcodes resolved in ID (j/jal) and EX (beq/bne)
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  // IF/ID record shared with the decode stage (65 bits)
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  localparam int unsigned IFID_W = $bits(ifid_t);

  // Bubble written into a pipeline register on flush or reset
  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.instr    = NOP_WORD;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register with flush (bubble) and enable (hold) controls.
// Ports: clk, reset (sync, active-high), flush, en, d (next record), q (held record).
// Flush takes priority over enable so a redirect always inserts a bubble.
module ifid_reg
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              en,
  input  logic [IFID_W-1:0] d,
  output logic [IFID_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= IFID_W'(ifid_bubble());
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux and IF/ID capture.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   imem_addr         - current PC to the combinational instruction memory
//   imem_instr        - instruction word for imem_addr
//   stall             - hazard-unit hold
//   id_redirect/id_target - jump resolved in ID
//   ex_redirect/ex_target - taken branch resolved in EX (wins over ID)
//   ifid_instr/ifid_pc_plus4/ifid_valid - IF/ID register contents
//   fetch_count       - instructions accepted into IF/ID since reset
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_plus4;
  logic              redirect;
  logic              fetch;
  ifid_t             ifid_d;
  ifid_t             ifid_q;
  logic [IFID_W-1:0] ifid_q_bits;

  // Wraps modulo 2^32 by construction
  assign pc_plus4 = pc + XLEN'(4);

  // Redirects override stall; a plain fetch only happens with neither
  assign redirect = ex_redirect | id_redirect;
  assign fetch    = ~redirect & ~stall;

  assign imem_addr = pc;

  // PC register: reset > EX redirect > ID redirect > stall hold > sequential
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (ex_redirect) begin
      pc <= ex_target;
    end else if (id_redirect) begin
      pc <= id_target;
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

  // Counts only instructions actually captured into IF/ID
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (fetch) begin
      fetch_count <= fetch_count + XLEN'(1);
    end
  end

  always_comb begin
    ifid_d          = ifid_bubble();
    ifid_d.instr    = imem_instr;
    ifid_d.pc_plus4 = pc_plus4;
    ifid_d.valid    = 1'b1;
  end

  ifid_reg u_ifid_reg (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .en    (~stall),
    .d     (IFID_W'(ifid_d)),
    .q     (ifid_q_bits)
  );

  assign ifid_q        = ifid_t'(ifid_q_bits);
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid    = ifid_q.valid;

endmodule
